// File: rtl/frogger_pkg.sv
// Shared types and colour constants for the lane colour mapper.
package frogger_pkg;

  typedef logic [10:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2
  } flash_state_e;

  localparam rgb_t COLOR_FROG  = rgb_t'(24'h28FA46);
  localparam rgb_t COLOR_BG    = rgb_t'(24'hFFFFFF);
  localparam rgb_t COLOR_HIT   = rgb_t'(24'hFF0000);
  localparam rgb_t COLOR_BLANK = rgb_t'(24'h000000);

endpackage

// File: rtl/lane_color_mapper_obj_hit.sv
// Combinational half-open rectangle test for one sprite; X may be signed so
// sprites can hang off the left edge of the screen.
module obj_hit #(
  parameter bit SIGNED_X = 1'b1
) (
  input  logic [10:0] obj_x,
  input  logic [10:0] obj_y,
  input  logic [10:0] obj_w,
  input  logic [10:0] obj_h,
  input  logic [10:0] px,
  input  logic [10:0] py,
  output logic        hit
);

  logic signed [12:0] x_lo;
  logic signed [12:0] x_hi;
  logic signed [12:0] p_x;
  logic        [11:0] y_hi;

  // 13-bit signed X keeps both a negative sprite and X+W near 2047 exact.
  always_comb begin
    x_lo = SIGNED_X ? {{2{obj_x[10]}}, obj_x} : {2'b00, obj_x};
    x_hi = x_lo + $signed({2'b00, obj_w});
    p_x  = $signed({2'b00, px});
    y_hi = {1'b0, obj_y} + {1'b0, obj_h};
    hit  = (p_x >= x_lo) && (p_x < x_hi) &&
           (py >= obj_y) && ({1'b0, py} < y_hi);
  end

endmodule

// File: rtl/lane_color_mapper.sv
// Two-stage pixel colour mapper: per-lane sprite hit test, then priority
// resolve and colour, with a frame-counted collision flash on the background.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | no flash, background white
// FLASH_ON  | background red, counting frames of the on phase
// FLASH_OFF | background white, counting frames of the off phase
module lane_color_mapper
  import frogger_pkg::*;
#(
  parameter int NUM_ROWS     = 8,
  parameter int MAX_OBJS     = 4,
  parameter int OBJ_W        = 80,
  parameter int OBJ_H        = 40,
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_CYCLES = 3
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           pix_valid,
  input  logic [10:0]                    DrawX,
  input  logic [10:0]                    DrawY,
  input  logic                           frame_start,
  input  logic [10:0]                    FrogX,
  input  logic [10:0]                    FrogY,
  input  logic [10:0]                    Frog_Width,
  input  logic [10:0]                    Frog_Height,
  input  logic [NUM_ROWS*MAX_OBJS*11-1:0] Obj_X,
  input  logic [NUM_ROWS*MAX_OBJS*11-1:0] Obj_Y,
  input  logic [NUM_ROWS*3-1:0]          Row_Count,
  input  logic [NUM_ROWS*24-1:0]         Row_Color,
  input  logic                           collision,
  output logic [7:0]                     Red,
  output logic [7:0]                     Green,
  output logic [7:0]                     Blue,
  output logic                           rgb_valid,
  output logic                           flash_active
);

  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int CW = $clog2(FLASH_CYCLES + 1);
  localparam int NS = NUM_ROWS * MAX_OBJS;

  localparam logic [1:0] S_IDLE      = IDLE;
  localparam logic [1:0] S_FLASH_ON  = FLASH_ON;
  localparam logic [1:0] S_FLASH_OFF = FLASH_OFF;

  logic [NS-1:0]       slot_hit;
  logic [NS-1:0]       slot_en;
  logic [NUM_ROWS-1:0] row_hit_c;
  logic                frog_hit_c;

  logic [NUM_ROWS-1:0] row_hit_q;
  logic                frog_hit_q;
  logic                valid_q;

  logic [1:0]          state;
  logic [FW-1:0]       frame_cnt;
  logic [CW-1:0]       cyc_cnt;

  rgb_t                pix_c;
  rgb_t                pix_q;

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    for (genvar k = 0; k < MAX_OBJS; k++) begin : g_slot
      localparam int I = r * MAX_OBJS + k;
      obj_hit #(.SIGNED_X(1'b1)) u_hit (
        .obj_x (Obj_X[I*11 +: 11]),
        .obj_y (Obj_Y[I*11 +: 11]),
        .obj_w (11'(OBJ_W)),
        .obj_h (11'(OBJ_H)),
        .px    (DrawX),
        .py    (DrawY),
        .hit   (slot_hit[I])
      );
      assign slot_en[I] = (k < int'(Row_Count[r*3 +: 3]));
    end
    assign row_hit_c[r] = |(slot_hit[r*MAX_OBJS +: MAX_OBJS] & slot_en[r*MAX_OBJS +: MAX_OBJS]);
  end

  obj_hit #(.SIGNED_X(1'b0)) u_frog_hit (
    .obj_x (FrogX),
    .obj_y (FrogY),
    .obj_w (Frog_Width),
    .obj_h (Frog_Height),
    .px    (DrawX),
    .py    (DrawY),
    .hit   (frog_hit_c)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      row_hit_q  <= '0;
      frog_hit_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      row_hit_q  <= row_hit_c;
      frog_hit_q <= frog_hit_c;
      valid_q    <= pix_valid;
    end
  end

  // Walk rows from lowest to highest priority so row 0 is written last.
  always_comb begin
    pix_c = (state == S_FLASH_ON) ? COLOR_HIT : COLOR_BG;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (row_hit_q[r]) pix_c = rgb_t'(Row_Color[r*24 +: 24]);
    end
    if (frog_hit_q) pix_c = COLOR_FROG;
    if (!valid_q)   pix_c = COLOR_BLANK;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pix_q     <= COLOR_BLANK;
      rgb_valid <= 1'b0;
    end else begin
      pix_q     <= pix_c;
      rgb_valid <= valid_q;
    end
  end

  assign Red   = pix_q.r;
  assign Green = pix_q.g;
  assign Blue  = pix_q.b;

  // Collision outranks frame_start in the same cycle: restart without counting.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      frame_cnt <= '0;
      cyc_cnt   <= '0;
    end else if (collision) begin
      state     <= S_FLASH_ON;
      frame_cnt <= '0;
      cyc_cnt   <= '0;
    end else if (frame_start && state != S_IDLE) begin
      if (frame_cnt == FW'(FLASH_FRAMES - 1)) begin
        frame_cnt <= '0;
        if (state == S_FLASH_ON) begin
          state <= S_FLASH_OFF;
        end else if (cyc_cnt == CW'(FLASH_CYCLES - 1)) begin
          state   <= S_IDLE;
          cyc_cnt <= '0;
        end else begin
          state   <= S_FLASH_ON;
          cyc_cnt <= cyc_cnt + 1'b1;
        end
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign flash_active = (state != S_IDLE);

endmodule

// File: tb/tb_lane_color_mapper.sv
// Randomised and directed check of lane_color_mapper against a plain
// arithmetic model of sprite priority and flash timing.
module tb_lane_color_mapper;

  localparam int NR = 8;
  localparam int MO = 4;
  localparam int OW = 80;
  localparam int OH = 40;
  localparam int FF = 8;
  localparam int FC = 3;

  logic                 Clk;
  logic                 Reset_n;
  logic                 pix_valid;
  logic [10:0]          DrawX, DrawY;
  logic                 frame_start;
  logic [10:0]          FrogX, FrogY, Frog_Width, Frog_Height;
  logic [NR*MO*11-1:0]  Obj_X, Obj_Y;
  logic [NR*3-1:0]      Row_Count;
  logic [NR*24-1:0]     Row_Color;
  logic                 collision;
  logic [7:0]           Red, Green, Blue;
  logic                 rgb_valid;
  logic                 flash_active;

  int checks = 0;
  int errors = 0;

  int          ox [NR][MO];
  int          oy [NR][MO];
  int          cnt[NR];
  logic [23:0] rc [NR];
  int          fx, fy, fw, fh;
  int          fn;  // frames since last collision, -1 when no flash

  lane_color_mapper dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .pix_valid    (pix_valid),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .frame_start  (frame_start),
    .FrogX        (FrogX),
    .FrogY        (FrogY),
    .Frog_Width   (Frog_Width),
    .Frog_Height  (Frog_Height),
    .Obj_X        (Obj_X),
    .Obj_Y        (Obj_Y),
    .Row_Count    (Row_Count),
    .Row_Color    (Row_Color),
    .collision    (collision),
    .Red          (Red),
    .Green        (Green),
    .Blue         (Blue),
    .rgb_valid    (rgb_valid),
    .flash_active (flash_active)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_model();
    for (int r = 0; r < NR; r++) begin
      for (int k = 0; k < MO; k++) begin
        Obj_X[(r*MO+k)*11 +: 11] = 11'(ox[r][k]);
        Obj_Y[(r*MO+k)*11 +: 11] = 11'(oy[r][k]);
      end
      Row_Count[r*3 +: 3] = 3'(cnt[r]);
      Row_Color[r*24 +: 24] = rc[r];
    end
    FrogX = 11'(fx); FrogY = 11'(fy); Frog_Width = 11'(fw); Frog_Height = 11'(fh);
  endtask

  function automatic bit flash_red();
    return (fn >= 0) && (fn < FF*2*FC) && (((fn / FF) % 2) == 0);
  endfunction

  function automatic logic [23:0] model_color(int x, int y);
    if (x >= fx && x < fx + fw && y >= fy && y < fy + fh) return 24'h28FA46;
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < MO; k++)
        if (k < cnt[r] && x >= ox[r][k] && x < ox[r][k] + OW &&
            y >= oy[r][k] && y < oy[r][k] + OH) return rc[r];
    return flash_red() ? 24'hFF0000 : 24'hFFFFFF;
  endfunction

  task automatic check_pix(input string tag, input int x, input int y);
    DrawX = 11'(x); DrawY = 11'(y); pix_valid = 1'b1;
    tick();
    tick();
    check(tag, {8'h00, Red, Green, Blue}, {8'h00, model_color(x, y)});
    check({tag, "_valid"}, {31'h0, rgb_valid}, 32'h1);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (fn >= 0) begin
      fn++;
      if (fn >= FF*2*FC) fn = -1;
    end
  endtask

  task automatic pulse_collision();
    collision = 1'b1;
    tick();
    collision = 1'b0;
    fn = 0;
  endtask

  task automatic check_flash(input string tag);
    check({tag, "_active"}, {31'h0, flash_active}, {31'h0, fn >= 0});
    check_pix(tag, 1500, 1900);
  endtask

  initial begin
    int x, y, r0, k0;
    Reset_n = 1'b0; pix_valid = 1'b0; DrawX = '0; DrawY = '0;
    frame_start = 1'b0; collision = 1'b0; fn = -1;
    for (int r = 0; r < NR; r++) begin
      for (int k = 0; k < MO; k++) begin ox[r][k] = 0; oy[r][k] = 0; end
      cnt[r] = 0; rc[r] = 24'h010101 * (r + 1);
    end
    fx = 100; fy = 200; fw = 40; fh = 40;
    apply_model();
    tick(); tick();
    check("reset_rgb", {8'h00, Red, Green, Blue}, 32'h0);
    check("reset_valid", {31'h0, rgb_valid}, 32'h0);
    check("reset_flash", {31'h0, flash_active}, 32'h0);
    Reset_n = 1'b1;
    tick(); tick();

    // frog hit with exact two-cycle latency
    DrawX = 11'd120; DrawY = 11'd220; pix_valid = 1'b1;
    tick();
    check("lat1_valid", {31'h0, rgb_valid}, 32'h0);
    check("lat1_rgb", {8'h00, Red, Green, Blue}, 32'h0);
    tick();
    check("frog_rgb", {8'h00, Red, Green, Blue}, 32'h0028FA46);
    check("frog_valid", {31'h0, rgb_valid}, 32'h1);
    check_pix("frog_edge_in", 139, 239);
    check_pix("frog_edge_out", 140, 220);

    fx = 2040; fy = 0; fw = 40; fh = 10; apply_model();
    check_pix("frog_x2047", 2047, 5);

    fx = 2000; fy = 2000; fw = 10; fh = 10;
    ox[2][0] = -20; oy[2][0] = 100; cnt[2] = 1; rc[2] = 24'h123456;
    apply_model();
    check_pix("wrap_x0", 0, 110);
    check_pix("wrap_x59", 59, 110);
    check_pix("wrap_x60", 60, 110);

    ox[1][0] = 300; oy[1][0] = 300; cnt[1] = 1; rc[1] = 24'hA1B2C3;
    ox[3][0] = 300; oy[3][0] = 300; cnt[3] = 1; rc[3] = 24'h0D0E0F;
    apply_model();
    check_pix("prio_row1", 310, 310);
    cnt[1] = 0; apply_model();
    check_pix("prio_row3", 310, 310);

    pix_valid = 1'b0;
    tick(); tick();
    check("blank_rgb", {8'h00, Red, Green, Blue}, 32'h0);
    check("blank_valid", {31'h0, rgb_valid}, 32'h0);

    for (int it = 0; it < 150; it++) begin
      for (int r = 0; r < NR; r++) begin
        for (int k = 0; k < MO; k++) begin
          ox[r][k] = int'($urandom_range(0, 1100)) - 100;
          oy[r][k] = int'($urandom_range(0, 600));
        end
        cnt[r] = int'($urandom_range(0, 7));
        rc[r]  = 24'($urandom);
      end
      fx = int'($urandom_range(0, 900)); fy = int'($urandom_range(0, 600));
      fw = int'($urandom_range(20, 60)); fh = int'($urandom_range(20, 60));
      apply_model();
      r0 = int'($urandom_range(0, NR-1)); k0 = int'($urandom_range(0, MO-1));
      x = ox[r0][k0] + int'($urandom_range(0, 99)) - 10;
      y = oy[r0][k0] + int'($urandom_range(0, 49)) - 5;
      if (x < 0) x = int'($urandom_range(0, 20));
      if (y < 0) y = int'($urandom_range(0, 20));
      check_pix("rand", x, y);
    end

    fx = 2000; fy = 2000; fw = 10; fh = 10; apply_model();
    pulse_collision();
    check_flash("flash_start");
    for (int f = 0; f < FF*2*FC; f++) begin
      pulse_frame();
      check_flash("flash_run");
    end

    pulse_collision();
    for (int f = 0; f < FF + 5; f++) pulse_frame();
    check_flash("pre_restart");
    collision = 1'b1; frame_start = 1'b1;
    tick();
    collision = 1'b0; frame_start = 1'b0; fn = 0;
    check_flash("restart");
    for (int f = 0; f < FF; f++) begin
      pulse_frame();
      check_flash("restart_run");
    end

    pulse_collision();
    pulse_frame(); pulse_frame();
    check_flash("pre_reset");
    Reset_n = 1'b0;
    tick();
    fn = -1;
    check("rst_flash", {31'h0, flash_active}, 32'h0);
    check("rst_rgb", {8'h00, Red, Green, Blue}, 32'h0);
    check("rst_valid", {31'h0, rgb_valid}, 32'h0);
    Reset_n = 1'b1;
    check_flash("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
